// File: rtl/processador_pkg.sv
// rtl/processador_pkg.sv - shared processor types and constants for the quantum counter
package processador_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned QUANTUM_DEFAULT = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2
  } estado_t;

endpackage

// File: rtl/contador_quantum_if.sv
// rtl/contador_quantum_if.sv - UC <-> quantum counter bundle; setQ/dadoQ only with CONTADOR_QUANTUM_PROG_EN
interface contador_quantum_if #(
  parameter int unsigned CW = 16
);

  logic [4:0]                           idProc;
  logic                                 swap_P;
  logic                                 status;
  logic                                 stall;
  logic [processador_pkg::ADDR_W-1:0]   pc_prox;
  logic                                 swap_SO;
  logic [processador_pkg::ADDR_W-1:0]   ultimo_pc;
  logic [processador_pkg::ADDR_W-1:0]   restante;
  logic [CW-1:0]                        preempcoes;

`ifdef CONTADOR_QUANTUM_PROG_EN
  logic                                 setQ;
  logic [processador_pkg::ADDR_W-1:0]   dadoQ;

  modport master (
    output idProc, swap_P, status, stall, pc_prox, setQ, dadoQ,
    input  swap_SO, ultimo_pc, restante, preempcoes
  );

  modport slave (
    input  idProc, swap_P, status, stall, pc_prox, setQ, dadoQ,
    output swap_SO, ultimo_pc, restante, preempcoes
  );
`else
  modport master (
    output idProc, swap_P, status, stall, pc_prox,
    input  swap_SO, ultimo_pc, restante, preempcoes
  );

  modport slave (
    input  idProc, swap_P, status, stall, pc_prox,
    output swap_SO, ultimo_pc, restante, preempcoes
  );
`endif

endinterface

// File: rtl/contador_sat.sv
// rtl/contador_sat.sv - saturating up-counter with enable
module contador_sat #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/contador_quantum.sv
// rtl/contador_quantum.sv - time-slice preemption counter; CONTADOR_QUANTUM_PROG_EN adds a programmable quantum
module contador_quantum
  import processador_pkg::*;
#(
  parameter int unsigned QUANTUM = QUANTUM_DEFAULT,
  parameter int unsigned CW      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  contador_quantum_if.slave bus
);

  // A zero quantum would never expire, so it behaves as a single instruction
  localparam logic [ADDR_W-1:0] QUANTUM_RST = (QUANTUM == 0) ? ADDR_W'(1) : ADDR_W'(QUANTUM);

  estado_t           state;
  logic              swap_so_q;
  logic [ADDR_W-1:0] ultimo_pc_q;
  logic [ADDR_W-1:0] restante_q;
  logic [ADDR_W-1:0] quantum;
  logic [CW-1:0]     preempcoes_q;

`ifdef CONTADOR_QUANTUM_PROG_EN
  // Quantum register; only read when swap_P (re)loads restante, so a write never disturbs the running slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quantum <= QUANTUM_RST;
    end else if (bus.setQ) begin
      quantum <= (bus.dadoQ == '0) ? ADDR_W'(1) : bus.dadoQ;
    end
  end
`else
  assign quantum = QUANTUM_RST;
`endif

  // Scheduler FSM: status=0 beats reload, reload beats commit/expiry; swap_SO is high exactly while in SWAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      swap_so_q   <= 1'b0;
      ultimo_pc_q <= '0;
      restante_q  <= '0;
    end else begin
      swap_so_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.swap_P && (bus.idProc != 5'd0)) begin
            state      <= RUN;
            restante_q <= quantum;
          end
        end
        RUN: begin
          if (!bus.status) begin
            state      <= IDLE;
            restante_q <= '0;
          end else if (bus.swap_P) begin
            restante_q <= quantum;
          end else if (!bus.stall) begin
            if (restante_q == ADDR_W'(1)) begin
              state       <= SWAP;
              restante_q  <= '0;
              ultimo_pc_q <= bus.pc_prox;
              swap_so_q   <= 1'b1;
            end else begin
              restante_q <= restante_q - ADDR_W'(1);
            end
          end
        end
        SWAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  contador_sat #(
    .W (CW)
  ) u_preempcoes (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == SWAP),
    .count (preempcoes_q)
  );

  assign bus.swap_SO    = swap_so_q;
  assign bus.ultimo_pc  = ultimo_pc_q;
  assign bus.restante   = restante_q;
  assign bus.preempcoes = preempcoes_q;

endmodule

// File: tb/tb_contador_quantum.sv
// tb/tb_contador_quantum.sv - self-checking bench for contador_quantum
module tb_contador_quantum;

  localparam int Q    = 4;
  localparam int CWT  = 2;
  localparam int MAXP = 3;

  logic clk = 1'b0;
  logic rst_n;

  contador_quantum_if #(.CW(CWT)) bus ();

  contador_quantum #(
    .QUANTUM (Q),
    .CW      (CWT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a user slice is a budget of commits; running out schedules one pulse cycle
  int          m_left;
  int          m_total;
  int          m_q;
  bit          m_user;
  bit          m_pulse;
  logic [31:0] m_pc;

  typedef struct {
    logic [4:0]  id;
    logic        sp;
    logic        st;
    logic        sl;
    logic [31:0] pc;
    logic        e_swap;
    logic [31:0] e_rest;
    logic [31:0] e_ult;
    logic [31:0] e_pre;
  } vec_t;

  vec_t tbl [10];

  int seq_stall [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
  int seq_rest  [8] = '{4, 3, 3, 3, 3, 2, 1, 0};
  int seq_swap  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  logic [31:0] pc_run;

  function automatic int exp_pre();
    return (m_total > MAXP) ? MAXP : m_total;
  endfunction

  task automatic model_reset();
    m_left  = 0;
    m_total = 0;
    m_q     = Q;
    m_user  = 0;
    m_pulse = 0;
    m_pc    = '0;
  endtask

  task automatic model_edge();
    int next_q;
    if (!rst_n) begin
      model_reset();
      return;
    end
    next_q = m_q;
`ifdef CONTADOR_QUANTUM_PROG_EN
    if (bus.setQ) next_q = (bus.dadoQ == 0) ? 1 : int'(bus.dadoQ);
`endif
    if (m_pulse) begin
      m_pulse = 0;
      m_total = m_total + 1;
    end else if (!m_user) begin
      if (bus.swap_P && bus.idProc != 0) begin
        m_user = 1;
        m_left = m_q;
      end
    end else if (!bus.status) begin
      m_user = 0;
      m_left = 0;
    end else if (bus.swap_P) begin
      m_left = m_q;
    end else if (!bus.stall) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_user  = 0;
        m_pulse = 1;
        m_pc    = bus.pc_prox;
      end
    end
    m_q = next_q;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic e_swap, input logic [31:0] e_rest,
                         input logic [31:0] e_ult, input logic [31:0] e_pre);
    chk({tag, ".swap_SO"},    32'(bus.swap_SO),    32'(e_swap));
    chk({tag, ".restante"},   bus.restante,        e_rest);
    chk({tag, ".ultimo_pc"},  bus.ultimo_pc,       e_ult);
    chk({tag, ".preempcoes"}, 32'(bus.preempcoes), e_pre);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_pulse, 32'(m_left), m_pc, 32'(exp_pre()));
  endtask

  task automatic drive(input logic r, input logic [4:0] id, input logic sp,
                       input logic st, input logic sl, input logic [31:0] pc);
    rst_n       = r;
    bus.idProc  = id;
    bus.swap_P  = sp;
    bus.status  = st;
    bus.stall   = sl;
    bus.pc_prox = pc;
    if (!r) model_reset();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef CONTADOR_QUANTUM_PROG_EN
    bus.setQ  = 1'b0;
    bus.dadoQ = '0;
`endif
    // Reset state
    drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    tick();
    chk_all("reset", 1'b0, 32'd0, 32'd0, 32'd0);

    // Nominal slice, idProc=0 ignored, early finish
    tbl[0] = '{5'd2, 1'b1, 1'b1, 1'b0, 32'd100, 1'b0, 32'd4, 32'd0,   32'd0};
    tbl[1] = '{5'd2, 1'b0, 1'b1, 1'b0, 32'd104, 1'b0, 32'd3, 32'd0,   32'd0};
    tbl[2] = '{5'd2, 1'b0, 1'b1, 1'b0, 32'd108, 1'b0, 32'd2, 32'd0,   32'd0};
    tbl[3] = '{5'd2, 1'b0, 1'b1, 1'b0, 32'd112, 1'b0, 32'd1, 32'd0,   32'd0};
    tbl[4] = '{5'd2, 1'b0, 1'b1, 1'b0, 32'd116, 1'b1, 32'd0, 32'd116, 32'd0};
    tbl[5] = '{5'd2, 1'b0, 1'b1, 1'b0, 32'd120, 1'b0, 32'd0, 32'd116, 32'd1};
    tbl[6] = '{5'd0, 1'b1, 1'b1, 1'b0, 32'd124, 1'b0, 32'd0, 32'd116, 32'd1};
    tbl[7] = '{5'd3, 1'b1, 1'b1, 1'b0, 32'd128, 1'b0, 32'd4, 32'd116, 32'd1};
    tbl[8] = '{5'd3, 1'b0, 1'b0, 1'b0, 32'd132, 1'b0, 32'd0, 32'd116, 32'd1};
    tbl[9] = '{5'd3, 1'b0, 1'b1, 1'b1, 32'd136, 1'b0, 32'd0, 32'd116, 32'd1};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].id, tbl[i].sp, tbl[i].st, tbl[i].sl, tbl[i].pc);
      tick();
      chk_all($sformatf("tbl%0d", i), tbl[i].e_swap, tbl[i].e_rest, tbl[i].e_ult, tbl[i].e_pre);
    end

    // Three stall cycles delay expiry by exactly three cycles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'd1, (i == 0), 1'b1, seq_stall[i][0], 32'd200 + 32'(4 * i));
      tick();
      chk($sformatf("stall%0d.restante", i), bus.restante, 32'(seq_rest[i]));
      chk($sformatf("stall%0d.swap_SO", i), 32'(bus.swap_SO), 32'(seq_swap[i]));
    end
    chk("stall.ultimo_pc", bus.ultimo_pc, 32'd228);
    drive(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    chk_all("stall.after", 1'b0, 32'd0, 32'd228, 32'd2);

    // status=0 on the last instruction wins over expiry
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, (i == 0), 1'b1, 1'b0, 32'd300 + 32'(4 * i));
      tick();
      chk($sformatf("fin%0d.restante", i), bus.restante, 32'(Q - i));
    end
    drive(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 32'd316);
    tick();
    chk_all("fin.exit", 1'b0, 32'd0, 32'd228, 32'd2);
    drive(1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 32'd320);
    tick();
    chk_all("fin.idle", 1'b0, 32'd0, 32'd228, 32'd2);

    // Reset in the middle of a slice, then saturation of the statistics counter
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd7, (i == 0), 1'b1, 1'b0, 32'd400 + 32'(4 * i));
      tick();
    end
    chk("rst.pre.restante", bus.restante, 32'd2);
    drive(1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 32'd412);
    tick();
    chk_all("rst.mid", 1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 32'd416 + 32'(4 * i));
      tick();
      chk($sformatf("rst.post%0d.swap_SO", i), 32'(bus.swap_SO), 32'd0);
      chk($sformatf("rst.post%0d.restante", i), bus.restante, 32'd0);
    end
    pc_run = 32'd500;
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < Q + 1; i++) begin
        drive(1'b1, 5'd5, (i == 0), 1'b1, 1'b0, pc_run);
        pc_run = pc_run + 32'd4;
        tick();
      end
      chk($sformatf("sat%0d.swap_SO", k), 32'(bus.swap_SO), 32'd1);
      chk($sformatf("sat%0d.ultimo_pc", k), bus.ultimo_pc, pc_run - 32'd4);
      drive(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, pc_run);
      tick();
      chk($sformatf("sat%0d.preempcoes", k), 32'(bus.preempcoes), (k > MAXP) ? 32'(MAXP) : 32'(k));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] id;
      id = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(($urandom_range(0, 79) != 0), id, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 11) != 0), ($urandom_range(0, 3) == 0), $urandom);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

`ifdef CONTADOR_QUANTUM_PROG_EN
    // Programming quantum 0 mid-slice: current slice unchanged, next load is a one-commit slice
    drive(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    drive(1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 32'd600);
    tick();
    chk("prog.load", bus.restante, 32'd4);
    bus.setQ  = 1'b1;
    bus.dadoQ = 32'd0;
    drive(1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 32'd604);
    tick();
    bus.setQ = 1'b0;
    chk("prog.keep", bus.restante, 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 32'd608 + 32'(4 * i));
      tick();
    end
    chk("prog.expire", 32'(bus.swap_SO), 32'd1);
    drive(1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 32'd620);
    tick();
    drive(1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 32'd624);
    tick();
    chk("prog.newq", bus.restante, 32'd1);
    drive(1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 32'd628);
    tick();
    chk("prog.swap", 32'(bus.swap_SO), 32'd1);
    chk("prog.ultimo_pc", bus.ultimo_pc, 32'd628);
    chk_model("prog.model");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/contador_quantum.md
CONTADOR_QUANTUM -- requirements
Module: contador_quantum

Interface
REQ-001 Parameters SHALL be, one per line:
  QUANTUM, 20, instructions a user process may execute before preemption; 0 is treated as 1
  CW, 16, width of the preemption statistics counter
REQ-002 Ports SHALL be, one per line:
  clk  in  1  processor clock; all state updates on posedge
  rst_n  in  1  reset, asynchronous, active-low
  idProc  in  5  currently selected process, 0 = SO
  swap_P  in  1  resume-process strobe from UC
  status  in  1  0 = current process finishing this cycle (from UC)
  stall  in  1  1 = no instruction commits this cycle
  pc_prox  in  32  address of the next instruction to execute
  swap_SO  out  1  one-cycle pulse: return to SO
  ultimo_pc  out  32  resume address of the preempted process
  restante  out  32  instructions left in the current quantum
  preempcoes  out  CW  saturating count of preemptions
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.

Function
REQ-004 The FSM SHALL have states IDLE (SO running), RUN (user process counting) and SWAP (preemption pulse).
REQ-005 In IDLE, a swap_P=1 with idProc!=0 SHALL move to RUN and load restante with the quantum; swap_P with idProc==0 SHALL be ignored.
REQ-006 In RUN, each cycle with stall=0 SHALL decrement restante by 1; a cycle with stall=1 SHALL hold it.
REQ-007 In RUN, when restante==1 and stall=0, the block SHALL go to SWAP, set restante to 0, and latch ultimo_pc<=pc_prox.
REQ-008 In SWAP, swap_SO SHALL be 1 for exactly that one cycle, preempcoes SHALL increment unless it is at all-ones, and the next state SHALL be IDLE.
REQ-009 swap_SO SHALL be a registered output, so it is stable across the following negedge.
REQ-010 In RUN, status=0 SHALL move to IDLE with restante<=0 and no swap_SO; this SHALL take priority over expiry in the same cycle.
REQ-011 In RUN, swap_P=1 SHALL reload restante with the quantum and stay in RUN.
REQ-012 swap_P in SWAP SHALL be ignored.
REQ-013 ultimo_pc SHALL hold its value until the next preemption.

Reset
REQ-014 While rst_n=0, the block SHALL set state=IDLE, swap_SO=0, ultimo_pc=0, restante=0, preempcoes=0, and set the quantum register to QUANTUM (clamped to at least 1).
REQ-015 If reset is asserted mid-RUN or mid-SWAP, it SHALL abort the operation with no swap_SO pulse after release.

Configuration
REQ-016 With CONTADOR_QUANTUM_PROG_EN defined, the block SHALL add inputs setQ (1) and dadoQ (32).
REQ-017 With CONTADOR_QUANTUM_PROG_EN defined, setQ=1 in any state SHALL load the quantum register with dadoQ, with 0 stored as 1.
REQ-018 With CONTADOR_QUANTUM_PROG_EN defined, a new quantum SHALL take effect only at the next load from swap_P.
REQ-019 Without CONTADOR_QUANTUM_PROG_EN, the setQ and dadoQ ports SHALL be absent and the quantum SHALL be the fixed parameter QUANTUM.

Structure
REQ-020 The shared package processador_pkg SHALL hold the FSM state type (IDLE/RUN/SWAP), the default QUANTUM, and the 32-bit address width constant.
REQ-021 The preemption statistics SHALL be implemented in a sub-module contador_sat: a parameterised-width saturating incrementer with enable and async active-low reset.

Verification
REQ-022 Scenario: QUANTUM=4, swap_P with idProc=2, no stall, pc_prox=100,104,... -> swap_SO pulses on the 5th posedge after swap_P, ultimo_pc=116, preempcoes=1.
REQ-023 Scenario: QUANTUM=4, stall=1 for 3 cycles mid-RUN -> swap_SO is delayed exactly 3 cycles and restante holds during the stall.
REQ-024 Scenario: status=0 in the same cycle as restante==1 -> no swap_SO, state IDLE, preempcoes unchanged.
REQ-025 Scenario: swap_P with idProc=0 -> state stays IDLE and restante=0.
REQ-026 Scenario: rst_n low for one cycle while restante=2 -> all outputs 0, no later pulse; with CW=2, four preemptions -> preempcoes=3 (saturated).
REQ-027 Scenario: with CONTADOR_QUANTUM_PROG_EN, setQ with dadoQ=0 in RUN -> current quantum unaffected, next swap_P loads restante=1, swap_SO follows after 1 commit.
